// File: rtl/shift_pkg.sv
// Shared FSM encoding and constants for the shift_recv serial symbol receiver.
package shift_pkg;

  localparam int DATA_W_DFLT = 5;
  localparam int SYM_MAX     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset value 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // two-stage capture of the incoming level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/shift_recv.sv
// Serial symbol receiver: start 1, DATA_W bits MSB first, stop 0, BIT_CYCLES clocks per bit.
// Optional symbol-order checker enabled by defining SHIFT_RECV_SEQ_CHECK_EN.
module shift_recv
  import shift_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int DATA_W     = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              seq_err
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic              din_s;
  logic              din_prev_r;
  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              frame_err_r;

`ifdef SHIFT_RECV_SEQ_CHECK_EN
  localparam logic [DATA_W-1:0] SYM_MAX_W = DATA_W'(SYM_MAX);
  localparam logic [DATA_W-1:0] SYM_ONE   = DATA_W'(1);

  logic              seq_err_r;
  logic [DATA_W-1:0] expected_r;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (din_s)
  );

  // receive FSM with registered result pulses; all timing is taken from the start-bit midpoint
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_prev_r   <= 1'b0;
      state_r      <= IDLE;
      cnt_r        <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef SHIFT_RECV_SEQ_CHECK_EN
      seq_err_r    <= 1'b0;
      expected_r   <= '0;
`endif
    end else begin
      din_prev_r   <= din_s;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef SHIFT_RECV_SEQ_CHECK_EN
      seq_err_r    <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          bit_cnt_r <= '0;
          // edge rather than level, so a line still high after a bad stop bit is ignored
          if (din_s && !din_prev_r) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == MID_CNT) begin
            cnt_r   <= '0;
            state_r <= din_s ? DATA : IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= '0;
            shift_r <= {shift_r[DATA_W-2:0], din_s};
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              state_r   <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= '0;
            state_r <= IDLE;
            if (!din_s) begin
              data_out_r   <= shift_r;
              data_valid_r <= 1'b1;
`ifdef SHIFT_RECV_SEQ_CHECK_EN
              seq_err_r    <= (shift_r != expected_r);
              expected_r   <= (shift_r >= SYM_MAX_W) ? '0 : shift_r + SYM_ONE;
`endif
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
`ifdef SHIFT_RECV_SEQ_CHECK_EN
  assign seq_err    = seq_err_r;
`else
  assign seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_shift_recv.sv
// Self-checking bench for shift_recv: directed frames plus randomized frames against an event-level model.
module tb_shift_recv;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [4:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       seq_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stray_seq = 0;

  // observed and expected pulse events
  int obs_cyc[$], obs_kind[$], obs_data[$], obs_seq[$];
  int exp_cyc[$], exp_kind[$], exp_data[$], exp_seq[$];

  int exp_sym   = 0;
  int last_good = 0;

  int r, sym;
  bit bad, prev_bad;

  shift_recv #(.BIT_CYCLES(4), .DATA_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // one clock: sample outputs on the falling edge, then drive the next line level
  task automatic tick(input logic b);
    @(negedge clk);
    cyc++;
    if (data_valid === 1'b1 || frame_err === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_kind.push_back({30'd0, frame_err, data_valid});
      obs_data.push_back(int'(data_out));
      obs_seq.push_back(int'(seq_err));
    end
    if (seq_err === 1'b1 && data_valid !== 1'b1) stray_seq++;
    din = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic glitch();
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
  endtask

  // drive one frame and predict its result pulse: 2 sync clocks + 26 to stop midpoint + 1 register
  task automatic send_frame(input int s, input bit stop_bad);
    logic [4:0] v;
    int start_cyc;
    v = s[4:0];
    start_cyc = cyc + 1;
    repeat (4) tick(1'b1);
    for (int i = 4; i >= 0; i--) repeat (4) tick(v[i]);
    repeat (4) tick(stop_bad);
    exp_cyc.push_back(start_cyc + 29);
    if (!stop_bad) begin
      exp_kind.push_back(1);
      exp_data.push_back(s);
`ifdef SHIFT_RECV_SEQ_CHECK_EN
      exp_seq.push_back((s != exp_sym) ? 1 : 0);
      exp_sym = (s >= 9) ? 0 : s + 1;
`else
      exp_seq.push_back(0);
`endif
      last_good = s;
    end else begin
      exp_kind.push_back(2);
      exp_data.push_back(last_good);
      exp_seq.push_back(0);
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, obs_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      chk({tag, "_cycle"}, obs_cyc[i],  exp_cyc[i]);
      chk({tag, "_kind"},  obs_kind[i], exp_kind[i]);
      chk({tag, "_data"},  obs_data[i], exp_data[i]);
      chk({tag, "_seq"},   obs_seq[i],  exp_seq[i]);
    end
    chk({tag, "_stray_seq"}, stray_seq, 0);
    obs_cyc.delete(); obs_kind.delete(); obs_data.delete(); obs_seq.delete();
    exp_cyc.delete(); exp_kind.delete(); exp_data.delete(); exp_seq.delete();
    stray_seq = 0;
  endtask

  initial begin
    din   = 1'b0;
    rst_n = 1'b0;
    idle(3);
    chk("rst_data_out",   data_out,   0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err",  frame_err,  0);
    chk("rst_seq_err",    seq_err,    0);
    rst_n = 1'b1;
    idle(3);

    // symbols 0..9 then 0, no idle gap between frames
    for (int s = 0; s <= 9; s++) send_frame(s, 1'b0);
    send_frame(0, 1'b0);
    idle(3);
    check_events("b2b");
    chk("b2b_hold", data_out, 0);

    // bad stop bit keeps previous symbol
    send_frame(1, 1'b0);
    send_frame(5, 1'b1);
    idle(3);
    check_events("stop_bad");
    chk("stop_bad_hold", data_out, 1);

    // single-clock glitch must be rejected, following frame received
    glitch();
    idle(2);
    check_events("glitch");
    send_frame(3, 1'b0);
    idle(3);
    check_events("after_glitch");
    chk("after_glitch_data", data_out, 3);

    // order checker: skip, in-order, out-of-range, resync
    send_frame(0, 1'b0);
    send_frame(1, 1'b0);
    send_frame(4, 1'b0);
    send_frame(5, 1'b0);
    send_frame(12, 1'b0);
    send_frame(0, 1'b0);
    idle(3);
    check_events("seq");

    send_frame(9, 1'b0);
    idle(3);
    check_events("pre_reset");

    // reset during data bit 3 of frame 10110
    repeat (4) tick(1'b1);
    repeat (4) tick(1'b1);
    repeat (4) tick(1'b0);
    repeat (4) tick(1'b1);
    repeat (2) tick(1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_out",   data_out,   0);
    chk("mid_rst_data_valid", data_valid, 0);
    chk("mid_rst_frame_err",  frame_err,  0);
    chk("mid_rst_seq_err",    seq_err,    0);
    idle(4);
    rst_n = 1'b1;
    exp_sym   = 0;
    last_good = 0;
    idle(2);
    send_frame(7, 1'b0);
    idle(3);
    check_events("post_reset");
    chk("post_reset_data", data_out, 7);

    send_frame(0, 1'b0);
    send_frame(2, 1'b0);
    idle(3);
    check_events("skip_02");

    // randomized frames, gaps, glitches and bad stop bits
    prev_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (prev_bad || r < 3) idle($urandom_range(1, 3));
      if (r == 0) glitch();
      bad = ($urandom_range(0, 5) == 0);
      sym = (r >= 5) ? exp_sym : $urandom_range(0, 31);
      send_frame(sym, bad);
      prev_bad = bad;
    end
    idle(3);
    check_events("rand");
    chk("rand_hold", data_out, last_good);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_recv.md
SHIFT_RECV -- requirements
Module: shift_recv

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, clk cycles per serial bit (even, >=2).
REQ-002 SHALL have parameter DATA_W, default 5, symbol width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge system clock, same clock as the transmitter.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din  input  1  serial line from the symbol serializer, idle low.
REQ-006 SHALL have port data_out  output  DATA_W  last good received symbol, held until the next good frame.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse marking a new data_out.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port seq_err  output  1  one-cycle pulse on a symbol-order violation; constant 0 when the checker is compiled out.

Function
REQ-010 SHALL define the frame as: start bit 1, DATA_W data bits MSB first, stop bit 0, each BIT_CYCLES clocks long.
REQ-011 SHALL pass din through a 2-flop synchronizer; all further logic uses the synchronized value (din_s).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 IDLE: on din_s 0->1 transition -> START, bit-cycle counter cleared.
REQ-014 START: at count BIT_CYCLES/2-1 (mid-bit), din_s=1 -> DATA; din_s=0 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: sample din_s every BIT_CYCLES clocks from the start-bit midpoint, shift left into a DATA_W register; after DATA_W samples -> STOP.
REQ-016 STOP: sample at mid-bit; 0 -> load data_out, pulse data_valid next cycle; 1 -> pulse frame_err next cycle, data_out unchanged; both -> IDLE.
REQ-017 Latency SHALL be exactly 1 clk from stop-bit mid sample to data_valid/frame_err, plus the 2-clk synchronizer delay from din.
REQ-018 After STOP, IDLE SHALL require din_s low before accepting a new start edge; back-to-back frames with no idle gap SHALL be received.
REQ-019 data_valid and frame_err SHALL never assert in the same cycle.
REQ-020 Bit-cycle counter width SHALL be clog2(BIT_CYCLES); bit counter SHALL count 0..DATA_W-1 and clear in IDLE.

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, data_out 0, data_valid 0, frame_err 0, seq_err 0, synchronizer flops 0, counters 0, expected symbol 0.
REQ-022 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes at the next 0->1 edge after release.

Configuration
REQ-023 Macro SHIFT_RECV_SEQ_CHECK_EN defined: checker holds expected symbol (reset 0); on each data_valid, data_out != expected -> seq_err pulse in the same cycle; expected <= 0 if data_out >= 9, else data_out+1 (resynchronize).
REQ-024 Macro SHIFT_RECV_SEQ_CHECK_EN undefined: no checker logic, seq_err tied 0.

Structure
REQ-025 Package shift_pkg SHALL hold the FSM state encoding, DATA_W default 5, SYM_MAX = 9.
REQ-026 The 2-flop synchronizer SHALL be sub-module sync_2ff (async active-low reset, reset value 0); all else in shift_recv.

Verification (BIT_CYCLES=4, DATA_W=5, macro defined unless noted)
REQ-027 Frames 0,1,...,9,0 back-to-back -> eleven data_valid pulses, data_out 0..9,0, no frame_err, no seq_err.
REQ-028 Frame symbol 5 with stop bit 1 -> frame_err one pulse, no data_valid, data_out keeps prior value.
REQ-029 1-clk high glitch on idle din -> no output pulses, FSM back in IDLE; following valid frame 3 received correctly.
REQ-030 Sequence 0,1,4,5 -> seq_err only on symbol 4, none on 5; symbol 12 -> seq_err, next expected 0.
REQ-031 rst_n asserted during data bit 3 of a frame -> all outputs 0 immediately, no pulse; next frame 7 -> data_out 7, data_valid.
REQ-032 Macro undefined, sequence 0,2 -> seq_err stays 0, both symbols delivered.
